branch_predictor: RTL

- Parametrised dynamic branch predictor for the RISC-V cores; the successor to the static "branch decided in EX" path of the single-cycle core.
- Combines a direct-mapped branch history table (N-bit saturating counters) with a tagged branch target buffer.
- Fetch queries it with the current pc and receives a same-cycle taken/target prediction.
- Execute reports resolved conditional branches (beq/bne/blt/bge/bltu/bgeu) back for training and mispredict counting.

---
 rtl/branch_predictor_pkg.sv | 15 +
 rtl/branch_predictor_if.sv | 30 +++
 rtl/branch_predictor_sat_counter.sv | 23 ++
 rtl/branch_predictor.sv | 118 +++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared types and default sizing for the dynamic branch predictor.
package branch_predictor_pkg;

    typedef enum logic {
        BP_INIT = 1'b0,
        BP_RUN  = 1'b1
    } bp_state_e;

    localparam int BP_XLEN_DEF     = 32;
    localparam int BP_IDX_BITS_DEF = 4;
    localparam int BP_TAG_BITS_DEF = 8;
    localparam int BP_CTR_BITS_DEF = 2;
    localparam int BP_CNT_W_DEF    = 16;

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and execute-side training signals of the branch predictor.
interface branch_predictor_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             ready;
    logic [XLEN-1:0]  pc;
    logic             pred_hit;
    logic             pred_taken;
    logic [XLEN-1:0]  pred_target;
    logic             upd_valid;
    logic [XLEN-1:0]  upd_pc;
    logic             upd_taken;
    logic [XLEN-1:0]  upd_target;
    logic             upd_pred_taken;
    logic [XLEN-1:0]  upd_pred_target;
    logic [CNT_W-1:0] mispred_cnt;

    modport master (
        input  ready, pred_hit, pred_taken, pred_target, mispred_cnt,
        output pc, upd_valid, upd_pc, upd_taken, upd_target,
               upd_pred_taken, upd_pred_target
    );

    modport slave (
        output ready, pred_hit, pred_taken, pred_target, mispred_cnt,
        input  pc, upd_valid, upd_pc, upd_taken, upd_target,
               upd_pred_taken, upd_pred_target
    );
endinterface

// File: rtl/branch_predictor_sat_counter.sv
// Combinational next value of a saturating up/down counter.
module branch_predictor_sat_counter #(
    parameter int CTR_BITS = 2
) (
    input  logic [CTR_BITS-1:0] value,
    input  logic                en,
    input  logic                inc,
    input  logic                dec,
    output logic [CTR_BITS-1:0] next
);

    always_comb begin
        next = value;
        if (en) begin
            if (inc && (value != '1)) begin
                next = value + 1'b1;
            end else if (dec && (value != '0)) begin
                next = value - 1'b1;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BHT of saturating counters plus tagged BTB, with sequential
// invalidation after reset and a saturating mispredict counter.
//
//   state   | meaning
//   BP_INIT | clearing valid[init_idx] one entry per cycle; no predictions/updates
//   BP_RUN  | predicting from the table and training on resolved branches
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int XLEN     = BP_XLEN_DEF,
    parameter int IDX_BITS = BP_IDX_BITS_DEF,
    parameter int TAG_BITS = BP_TAG_BITS_DEF,
    parameter int CTR_BITS = BP_CTR_BITS_DEF,
    parameter int CNT_W    = BP_CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    branch_predictor_if.slave  bus
);

    localparam int ENTRIES = 2 ** IDX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);

    bp_state_e            state_q;
    logic [IDX_BITS-1:0]  init_idx_q;
    logic                 ready_q;
    logic [CNT_W-1:0]     mispred_cnt_q;

    logic                 valid_q  [ENTRIES];
    logic [TAG_BITS-1:0]  tag_q    [ENTRIES];
    logic [XLEN-1:0]      target_q [ENTRIES];
    logic [CTR_BITS-1:0]  ctr_q    [ENTRIES];

    logic [IDX_BITS-1:0]  lk_idx;
    logic [TAG_BITS-1:0]  lk_tag;
    logic                 lk_hit;
    logic [IDX_BITS-1:0]  upd_idx;
    logic [TAG_BITS-1:0]  upd_tag;
    logic                 upd_hit;
    logic [CTR_BITS-1:0]  ctr_next;
    logic                 mispred;
    logic                 unused_pc_bits;

    assign lk_idx  = bus.pc[IDX_BITS+1:2];
    assign lk_tag  = bus.pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
    assign upd_idx = bus.upd_pc[IDX_BITS+1:2];
    assign upd_tag = bus.upd_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
    assign unused_pc_bits = ^{bus.pc, bus.upd_pc};

    // Lookup reads the pre-edge table; an update in the same cycle is not bypassed.
    assign lk_hit          = ready_q && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign bus.pred_hit    = lk_hit;
    assign bus.pred_taken  = lk_hit && ctr_q[lk_idx][CTR_BITS-1];
    assign bus.pred_target = lk_hit ? target_q[lk_idx] : '0;
    assign bus.ready       = ready_q;
    assign bus.mispred_cnt = mispred_cnt_q;

    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign mispred = (bus.upd_taken != bus.upd_pred_taken) ||
                     (bus.upd_taken && bus.upd_pred_taken &&
                      (bus.upd_target != bus.upd_pred_target));

    branch_predictor_sat_counter #(.CTR_BITS(CTR_BITS)) u_upd_ctr (
        .value (ctr_q[upd_idx]),
        .en    (upd_hit),
        .inc   (bus.upd_taken),
        .dec   (!bus.upd_taken),
        .next  (ctr_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= BP_INIT;
            init_idx_q    <= '0;
            ready_q       <= 1'b0;
            mispred_cnt_q <= '0;
        end else begin
            case (state_q)
                BP_INIT: begin
                    init_idx_q <= init_idx_q + 1'b1;
                    if (init_idx_q == '1) begin
                        state_q <= BP_RUN;
                        ready_q <= 1'b1;
                    end
                end
                BP_RUN: begin
                    if (bus.upd_valid && mispred && (mispred_cnt_q != '1)) begin
                        mispred_cnt_q <= mispred_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= BP_INIT;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Table contents need no reset: INIT invalidates every entry before use.
    always_ff @(posedge clk) begin
        if (state_q == BP_INIT) begin
            valid_q[init_idx_q] <= 1'b0;
        end else if (bus.upd_valid) begin
            if (upd_hit) begin
                ctr_q[upd_idx] <= ctr_next;
                if (bus.upd_taken) begin
                    target_q[upd_idx] <= bus.upd_target;
                end
            end else if (bus.upd_taken) begin
                valid_q[upd_idx]  <= 1'b1;
                tag_q[upd_idx]    <= upd_tag;
                target_q[upd_idx] <= bus.upd_target;
                ctr_q[upd_idx]    <= CTR_WEAK;
            end
        end
    end

endmodule
